// File: rtl/alu_arb_pkg.sv
// Shared-ALU arbiter types: op codes, FSM state type and op-decode helper.
package alu_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Wide enough for the largest multiply settle time (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_defined(input logic [2:0] ctrl);
    return (ctrl == OP_AND) || (ctrl == OP_OR) || (ctrl == OP_ADD) ||
           (ctrl == OP_SUB) || (ctrl == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way grant picker, combinational, one-hot out; no valid gives no grant.
// On a tie the requester not named by i_last wins (i_last tied high = req0 priority).
module alu_arb_pick (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      o_grant = i_last ? 2'b01 : 2'b10;
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one combinational ALU, one op in flight; accept-to-rsp 2 cycles (MUL: MUL_LAT+1).
// Ready only in IDLE, response held until rsp_ready_i; ALU_ARB_RR_EN selects round-robin, else req0 priority.
module alu_share_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ctrl_i,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  input  logic        rsp_ready_i
);

  import alu_arb_pkg::*;

  localparam logic [CNT_W-1:0] LP_MUL_CNT = CNT_W'(MUL_LAT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_alu_d1;
  logic [31:0]        r_alu_d2;
  logic [2:0]         r_alu_ctrl;
  logic               r_rsp_vld;
  logic               r_rsp_id;
  logic [31:0]        r_rsp_data;

  logic [1:0]         w_grant;
  logic               w_last;
  logic               w_acc;
  logic [31:0]        w_sel_d1;
  logic [31:0]        w_sel_d2;
  logic [2:0]         w_sel_ctrl;

`ifdef ALU_ARB_RR_EN
  logic r_last_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last_grant <= 1'b1;
    end else if (w_acc) begin
      r_last_grant <= w_grant[1];
    end
  end

  assign w_last = r_last_grant;
`else
  // Pretending req1 won last makes the picker favour req0 on every tie.
  assign w_last = 1'b1;
`endif

  alu_arb_pick u_pick (
    .i_valid0 (req0_valid_i),
    .i_valid1 (req1_valid_i),
    .i_last   (w_last),
    .o_grant  (w_grant)
  );

  assign req0_ready_o = (r_state == ST_IDLE) && w_grant[0];
  assign req1_ready_o = (r_state == ST_IDLE) && w_grant[1];
  assign w_acc        = req0_ready_o || req1_ready_o;

  assign w_sel_d1   = w_grant[1] ? req1_data1_i : req0_data1_i;
  assign w_sel_d2   = w_grant[1] ? req1_data2_i : req0_data2_i;
  assign w_sel_ctrl = w_grant[1] ? req1_ctrl_i  : req0_ctrl_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_alu_d1   <= '0;
      r_alu_d2   <= '0;
      r_alu_ctrl <= OP_AND;
      r_rsp_vld  <= 1'b0;
      r_rsp_id   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_alu_d1   <= w_sel_d1;
            r_alu_d2   <= w_sel_d2;
            r_alu_ctrl <= w_sel_ctrl;
            r_rsp_id   <= w_grant[1];
            r_cnt      <= (w_sel_ctrl == OP_MUL) ? LP_MUL_CNT : CNT_W'(1);
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == CNT_W'(1)) begin
            // Undefined op codes return zero whatever the ALU produced.
            r_rsp_data <= op_defined(r_alu_ctrl) ? alu_data_i : 32'd0;
            r_rsp_vld  <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_vld <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_data1_o = r_alu_d1;
  assign alu_data2_o = r_alu_d2;
  assign alu_ctrl_o  = r_alu_ctrl;
  assign rsp_valid_o = r_rsp_vld;
  assign rsp_id_o    = r_rsp_id;
  assign rsp_data_o  = r_rsp_data;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
// Expected grant order follows ALU_ARB_RR_EN when the bench is built with it.
module tb_alu_share_arbiter;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
  logic [2:0]  req0_ctrl_i, req1_ctrl_i;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]  alu_ctrl_o;
  logic        rsp_valid_o, rsp_id_o, rsp_ready_i;
  logic [31:0] rsp_data_o;

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          acc;
    int          lat;
  } sb_t;

  sb_t sb[$];
  bit  acc_ids[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  bit  prev_vld = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU model; undefined codes return junk so a missing zeroing shows up.
  function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return a * b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] exp_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (c == 3'b011 || c == 3'b100 || c == 3'b101) return 32'd0;
    return alu_fn(c, a, b);
  endfunction

  assign alu_data_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);

  alu_share_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_data1_i (req0_data1_i),
    .req0_data2_i (req0_data2_i),
    .req0_ctrl_i  (req0_ctrl_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_data1_i (req1_data1_i),
    .req1_data2_i (req1_data2_i),
    .req1_ctrl_i  (req1_ctrl_i),
    .alu_data1_o  (alu_data1_o),
    .alu_data2_o  (alu_data2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_data_i   (alu_data_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_ready_i  (rsp_ready_i)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_acc(input bit id, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    sb_t e;
    e.id   = id;
    e.data = exp_fn(c, a, b);
    e.acc  = cyc;
    e.lat  = (c == 3'b111) ? MUL_LAT + 1 : 2;
    sb.push_back(e);
    acc_ids.push_back(id);
  endtask

  // Accepts are recorded when seen; responses are checked for latency on rise and content on handshake.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_i) begin
      if (req0_valid_i && req0_ready_o) push_acc(1'b0, req0_ctrl_i, req0_data1_i, req0_data2_i);
      if (req1_valid_i && req1_ready_o) push_acc(1'b1, req1_ctrl_i, req1_data1_i, req1_data2_i);
      if (rsp_valid_o && !prev_vld) begin
        if (sb.size() == 0) chk("rsp_unexpected", 72'(rsp_valid_o), 72'd0);
        else chk("latency", 72'(cyc - sb[0].acc), 72'(sb[0].lat));
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected_hs", 72'(rsp_valid_o), 72'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 72'(rsp_id_o), 72'(e.id));
          chk("rsp_data", 72'(rsp_data_o), 72'(e.data));
        end
      end
    end
    prev_vld = rsp_valid_o;
  end

  task automatic set_req(input bit id, input bit v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid_i = v; req1_ctrl_i = c; req1_data1_i = a; req1_data2_i = b;
    end else begin
      req0_valid_i = v; req0_ctrl_i = c; req0_data1_i = a; req0_data2_i = b;
    end
  endtask

  task automatic clr_req(input bit id);
    if (id) req1_valid_i = 1'b0;
    else    req0_valid_i = 1'b0;
  endtask

  // Drive one request, wait (bounded) for its ready, return just after the accepting edge.
  task automatic issue(input bit id, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    @(posedge clk); #1;
    set_req(id, 1'b1, c, a, b);
    @(negedge clk); #1;
    while (!(id ? req1_ready_o : req0_ready_o) && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    chk("accept_seen", 72'(k < 40), 72'd1);
    @(posedge clk); #1;
    clr_req(id);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    @(negedge clk); #1;
    while ((sb.size() != 0 || rsp_valid_o) && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    chk({tag, "_drain"}, 72'(k < 50), 72'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    int seen;
    bit exp_id;

    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rsp_valid", 72'(rsp_valid_o), 72'd0);
    chk("rst_rsp_id",    72'(rsp_id_o),    72'd0);
    chk("rst_rsp_data",  72'(rsp_data_o),  72'd0);
    chk("rst_alu",       72'({alu_ctrl_o, alu_data1_o, alu_data2_o}), 72'd0);
    chk("rst_ready",     72'({req0_ready_o, req1_ready_o}), 72'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // ADD 5+7 on req0 alone
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'b010, 32'd5, 32'd7);
    @(negedge clk); #1;
    chk("add_ready_idle", 72'({req0_ready_o, req1_ready_o}), 72'b10);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("add_ready_exec", 72'({req0_ready_o, req1_ready_o}), 72'b00);
    @(posedge clk); #1;
    clr_req(1'b0);
    drain("add");
    chk("add_data", 72'(rsp_data_o), 72'd12);
    chk("add_id",   72'(rsp_id_o),   72'd0);

    // MUL 6*7 on req1: ALU operands must stay put for every EXEC cycle
    issue(1'b1, 3'b111, 32'd6, 32'd7);
    repeat (MUL_LAT) begin
      @(negedge clk); #1;
      chk("mul_alu_stable", 72'({rsp_valid_o, alu_ctrl_o, alu_data1_o, alu_data2_o}),
          72'({1'b0, 3'b111, 32'd6, 32'd7}));
    end
    drain("mul");
    chk("mul_data", 72'(rsp_data_o), 72'd42);
    chk("mul_id",   72'(rsp_id_o),   72'd1);

    // Undefined op code returns zero after one EXEC cycle
    issue(1'b0, 3'b100, 32'd3, 32'd4);
    drain("undef");
    chk("undef_data", 72'(rsp_data_o), 72'd0);

    // Backpressure: response held while the other requester waits
    rsp_ready_i = 1'b0;
    issue(1'b0, 3'b000, 32'hFF00, 32'h0FF0);
    set_req(1'b1, 1'b1, 3'b001, 32'd1, 32'd2);
    k = 0;
    @(negedge clk); #1;
    while (!rsp_valid_o && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("bp_rsp_seen", 72'(k < 20), 72'd1);
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_hold", 72'({rsp_valid_o, rsp_id_o, rsp_data_o, req0_ready_o, req1_ready_o}),
          72'({1'b1, 1'b0, 32'h0F00, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    rsp_ready_i = 1'b1;
    @(negedge clk); #1;
    chk("bp_release_no_accept", 72'(req1_ready_o), 72'd0);
    @(negedge clk); #1;
    chk("bp_release_plus1", 72'(req1_ready_o), 72'd1);
    @(posedge clk); #1;
    clr_req(1'b1);
    drain("bp");
    chk("bp_or_data", 72'(rsp_data_o), 72'd3);

    // Both requesters valid continuously for four accepts
    base = acc_ids.size();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'b110, 32'd9, 32'd4);
    set_req(1'b1, 1'b1, 3'b001, 32'hF0, 32'h0F);
    k = 0;
    @(negedge clk); #1;
    while (acc_ids.size() - base < 4 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    chk("both_four_accepts", 72'(acc_ids.size() - base), 72'd4);
    @(posedge clk); #1;
    clr_req(1'b0);
    clr_req(1'b1);
    drain("both");
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_id = (i % 2) == 1;
`else
      exp_id = 1'b0;
`endif
      if (base + i < acc_ids.size()) chk("both_grant_order", 72'(acc_ids[base + i]), 72'(exp_id));
    end

    // Reset in the middle of a multiply discards it
    issue(1'b0, 3'b111, 32'd3, 32'd4);
    @(posedge clk); #1;
    rst_i = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk); #1;
    chk("midrst_outputs", 72'({rsp_valid_o, rsp_id_o, rsp_data_o, alu_ctrl_o, alu_data1_o}), 72'd0);
    chk("midrst_alu_d2", 72'(alu_data2_o), 72'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk); #1;
      seen += int'(rsp_valid_o);
    end
    chk("midrst_no_rsp", 72'(seen), 72'd0);

    // First tie after reset goes to req0 in either grant mode
    base = acc_ids.size();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 3'b010, 32'd100, 32'd23);
    set_req(1'b1, 1'b1, 3'b001, 32'hF0, 32'h0F);
    k = 0;
    @(negedge clk); #1;
    while (acc_ids.size() == base && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("postrst_accept_seen", 72'(k < 20), 72'd1);
    if (acc_ids.size() > base) chk("postrst_first_grant", 72'(acc_ids[base]), 72'd0);
    @(posedge clk); #1;
    clr_req(1'b0);
    clr_req(1'b1);
    drain("postrst");
    chk("postrst_data", 72'(rsp_data_o), 72'd123);
    chk("sb_empty", 72'(sb.size()), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 3: cycles the ALU output is allowed to settle for multiply (ctrl 3'b111); legal range 1..15.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 req0_valid_i / req1_valid_i  input  1  requester N has an operation.
REQ-005 req0_ready_o / req1_ready_o  output  1  requester N's operation accepted this cycle.
REQ-006 reqN_data1_i, reqN_data2_i  input  32  operands of requester N; reqN_ctrl_i  input  3  ALU op code.
REQ-007 alu_data1_o, alu_data2_o  output  32; alu_ctrl_o  output  3  drive the shared combinational ALU.
REQ-008 alu_data_i  input  32  ALU result.
REQ-009 rsp_valid_o  output  1; rsp_id_o  output  1 (owning requester); rsp_data_o  output  32; rsp_ready_i  input  1  consumer accepts response.

Function
REQ-010 FSM states IDLE, EXEC, RESP; the block SHALL hold at most one operation at a time.
REQ-011 In IDLE, exactly one reqN_ready_o SHALL be high, combinationally, for the granted requester with valid high; both low if no valid.
REQ-012 Handshake: transfer when reqN_valid_i && reqN_ready_o; operands, ctrl and id latched; IDLE -> EXEC.
REQ-013 ready outputs SHALL be low in EXEC and RESP.
REQ-014 In EXEC, alu_* outputs SHALL be driven from latched registers, constant for the whole EXEC period.
REQ-015 EXEC lasts 1 cycle for ctrl 000/001/010/110, MUL_LAT cycles for 111 (down-counter loaded on accept).
REQ-016 Undefined ctrl (011/100/101) SHALL take 1 EXEC cycle and produce rsp_data_o = 0.
REQ-017 On last EXEC cycle, alu_data_i SHALL be captured into rsp_data_o; EXEC -> RESP.
REQ-018 In RESP, rsp_valid_o = 1 and rsp_id_o/rsp_data_o stable until rsp_ready_i; on rsp_ready_i, RESP -> IDLE.
REQ-019 A new request SHALL NOT be accepted in the cycle RESP completes; earliest accept is the following IDLE cycle.
REQ-020 Outside EXEC, alu_* outputs SHALL hold their last latched values (no toggling).
REQ-021 Latency accept-to-rsp_valid: 2 cycles for single-cycle ops, MUL_LAT+1 for multiply.
REQ-022 Requester holding valid without ready SHALL NOT lose its request; arbiter has no timeouts.

Reset
REQ-023 On rst_i: state IDLE, rsp_valid_o 0, rsp_id_o 0, rsp_data_o 0, alu_data1_o/alu_data2_o 0, alu_ctrl_o 3'b000, counter 0, last-grant register = 1.
REQ-024 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation without a response.

Configuration
REQ-025 Macro ALU_ARB_RR_EN defined: round-robin; on simultaneous valids, grant goes to the requester not granted last; last-grant updates on each accept.
REQ-026 ALU_ARB_RR_EN undefined: fixed priority, req0 always wins on simultaneous valids; last-grant register absent.

Structure
REQ-027 Package alu_arb_pkg SHALL hold ALU op-code constants (AND 000, OR 001, ADD 010, SUB 110, MUL 111) and the FSM state type.
REQ-028 Grant logic SHALL be a sub-module alu_arb_pick (two valids + last-grant in, one-hot grant out); datapath and FSM stay in the top.

Verification
REQ-029 req0 ADD 5+7 alone, rsp_ready_i=1 -> req0_ready_o one cycle, rsp_valid_o 2 cycles later, rsp_id_o 0, rsp_data_o 12.
REQ-030 req1 MUL 6*7, MUL_LAT=3 -> rsp_valid_o 4 cycles after accept, rsp_data_o 42, alu_* stable for 3 EXEC cycles.
REQ-031 Both valid continuously with SUB 9-4 (req0) and OR 0xF0|0x0F (req1), RR on -> ids alternate 0,1,0,1, data 5/0xFF; RR off -> all grants to req0.
REQ-032 rsp_ready_i held low 5 cycles in RESP -> rsp_valid_o/data stable, both ready low, no new accept until release +1.
REQ-033 rst_i asserted during multiply EXEC -> next cycle IDLE, rsp_valid_o 0, outputs at reset values, no response emitted.
REQ-034 ctrl 3'b100 -> 1-cycle EXEC, rsp_data_o 0.
